// File: rtl/pipe_pkg.sv
// pipe_pkg: shared field widths, memory opcodes and the MEM-stage state type.
package pipe_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  localparam logic [OP_W-1:0] OP_LW = 4'h8;
  localparam logic [OP_W-1:0] OP_SW = 4'h9;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; non-memory ops pass in one cycle, loads/stores wait for mem_ack.
// Build macro MEM_TIMEOUT_EN adds a WAIT timeout that completes the instruction with fault_o=1.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] alu_reg_i,
  input  logic              writeReg_i,
  input  logic [REG_W-1:0]  reg1_i,
  input  logic [REG_W-1:0]  reg2_i,
  input  logic [REG_W-1:0]  imm_i,
  output logic              stall_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_o,
  output logic [OP_W-1:0]   opcode_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] alu_reg_o,
  output logic              writeReg_o,
  output logic [REG_W-1:0]  reg1_o,
  output logic [REG_W-1:0]  reg2_o,
  output logic [REG_W-1:0]  imm_o,
  output logic [DATA_W-1:0] q_o,
  output logic              fault_o
);

  mem_state_t        state;
  logic [OP_W-1:0]   op_p0;
  logic [DATA_W-1:0] data1_p0;
  logic [DATA_W-1:0] alu_p0;
  logic              wr_p0;
  logic [REG_W-1:0]  reg1_p0;
  logic [REG_W-1:0]  reg2_p0;
  logic [REG_W-1:0]  imm_p0;
  logic              is_mem;
  logic              tmo;

  assign is_mem    = (opcode_i == OP_LW) || (opcode_i == OP_SW);
  assign stall_o   = (state == WAIT);
  assign mem_req   = stall_o;
  assign mem_we    = stall_o && (op_p0 == OP_SW);
  assign mem_addr  = alu_p0;
  assign mem_wdata = data1_p0;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       fault_p1;

  // wait_cnt holds the number of WAIT cycles already completed; an ack in the last cycle wins.
  assign tmo     = stall_o && !mem_ack && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign fault_o = fault_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      fault_p1 <= 1'b0;
    end else begin
      fault_p1 <= tmo;
      wait_cnt <= stall_o ? wait_cnt + 8'd1 : 8'd0;
    end
  end
`else
  assign tmo     = 1'b0;
  assign fault_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_p0      <= '0;
      data1_p0   <= '0;
      alu_p0     <= '0;
      wr_p0      <= 1'b0;
      reg1_p0    <= '0;
      reg2_p0    <= '0;
      imm_p0     <= '0;
      valid_o    <= 1'b0;
      opcode_o   <= '0;
      data1_o    <= '0;
      alu_reg_o  <= '0;
      writeReg_o <= 1'b0;
      reg1_o     <= '0;
      reg2_o     <= '0;
      imm_o      <= '0;
      q_o        <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && is_mem) begin
            // Memory ops are parked in the _p0 copy so outputs keep their last value until completion.
            op_p0    <= opcode_i;
            data1_p0 <= data1_i;
            alu_p0   <= alu_reg_i;
            wr_p0    <= writeReg_i;
            reg1_p0  <= reg1_i;
            reg2_p0  <= reg2_i;
            imm_p0   <= imm_i;
            state    <= WAIT;
          end else if (valid_i) begin
            valid_o    <= 1'b1;
            opcode_o   <= opcode_i;
            data1_o    <= data1_i;
            alu_reg_o  <= alu_reg_i;
            writeReg_o <= writeReg_i;
            reg1_o     <= reg1_i;
            reg2_o     <= reg2_i;
            imm_o      <= imm_i;
            q_o        <= '0;
          end
        end
        WAIT: begin
          if (mem_ack || tmo) begin
            valid_o    <= 1'b1;
            opcode_o   <= op_p0;
            data1_o    <= data1_p0;
            alu_reg_o  <= alu_p0;
            writeReg_o <= wr_p0 && !tmo;
            reg1_o     <= reg1_p0;
            reg2_o     <= reg2_p0;
            imm_o      <= imm_p0;
            q_o        <= (mem_ack && op_p0 == OP_LW) ? mem_rdata : '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a transaction-level model.
module tb_mem_stage;
  import pipe_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] d1;
    logic [7:0] alu;
    logic       wr;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] imm;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i, writeReg_i, mem_ack;
  logic [3:0] opcode_i;
  logic [7:0] data1_i, alu_reg_i, mem_rdata;
  logic [2:0] reg1_i, reg2_i, imm_i;
  logic       stall_o, mem_req, mem_we, valid_o, writeReg_o, fault_o;
  logic [7:0] mem_addr, mem_wdata, data1_o, alu_reg_o, q_o;
  logic [3:0] opcode_o;
  logic [2:0] reg1_o, reg2_o, imm_o;

  logic [39:0] obs;
  logic [18:0] bus;
  logic [37:0] last;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i), .data1_i(data1_i),
    .alu_reg_i(alu_reg_i), .writeReg_i(writeReg_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .imm_i(imm_i), .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_o(valid_o), .opcode_o(opcode_o), .data1_o(data1_o), .alu_reg_o(alu_reg_o),
    .writeReg_o(writeReg_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o),
    .q_o(q_o), .fault_o(fault_o)
  );

  assign obs = {valid_o, fault_o, opcode_o, data1_o, alu_reg_o, writeReg_o, reg1_o, reg2_o, imm_o, q_o};
  assign bus = {stall_o, mem_req, mem_we, mem_addr, mem_wdata};

  // Reference: a completed instruction carries its own fields; loads return rdata, a timeout clears wr and q.
  function automatic logic [39:0] exp_out(instr_t i, logic [7:0] rd, logic flt);
    logic [7:0] q;
    q = (!flt && i.op == OP_LW) ? rd : 8'h00;
    return {1'b1, flt, i.op, i.d1, i.alu, i.wr & ~flt, i.r1, i.r2, i.imm, q};
  endfunction

  function automatic instr_t rand_instr(logic [3:0] op);
    instr_t i;
    i.op  = op;
    i.d1  = 8'($urandom);
    i.alu = 8'($urandom);
    i.wr  = 1'($urandom);
    i.r1  = 3'($urandom);
    i.r2  = 3'($urandom);
    i.imm = 3'($urandom);
    return i;
  endfunction

  function automatic logic [3:0] rand_alu_op();
    logic [3:0] op;
    op = 4'($urandom);
    while (op == OP_LW || op == OP_SW) op = 4'($urandom);
    return op;
  endfunction

  task automatic present(instr_t i, logic v);
    valid_i    = v;
    opcode_i   = i.op;
    data1_i    = i.d1;
    alu_reg_i  = i.alu;
    writeReg_i = i.wr;
    reg1_i     = i.r1;
    reg2_i     = i.r2;
    imm_i      = i.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    present(rand_instr(OP_LW), 1'b1);
    mem_ack = 1'b1;
    mem_rdata = 8'hFF;
    step();
    step();
    rst = 1'b0;
    present(rand_instr(4'h0), 1'b0);
    mem_ack = 1'b0;
    checks++;
    if (obs !== 40'h0) begin errors++; $display("FAIL reset_out: got %h exp %h", obs, 40'h0); end
    checks++;
    if (bus !== 19'h0) begin errors++; $display("FAIL reset_bus: got %h exp %h", bus, 19'h0); end
    last = '0;
    step();
    checks++;
    if (obs !== 40'h0) begin errors++; $display("FAIL reset_idle: got %h exp %h", obs, 40'h0); end
  endtask

  task automatic test_nonmem();
    instr_t i;
    logic [39:0] e;
    for (int t = 0; t < 8; t++) begin
      i = rand_instr(rand_alu_op());
      if (t == 0) begin i.op = 4'h1; i.alu = 8'h3C; i.wr = 1'b1; end
      present(i, 1'b1);
      step();
      e = exp_out(i, 8'h00, 1'b0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL nonmem_out[%0d]: got %h exp %h", t, obs, e); end
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL nonmem_stall[%0d]: got %b exp 0", t, stall_o); end
      last = e[37:0];
      present(rand_instr(4'h0), 1'b0);
      mem_ack = 1'b1;
      mem_rdata = 8'($urandom);
      step();
      mem_ack = 1'b0;
      checks++;
      if ({obs, stall_o} !== {2'b00, last, 1'b0}) begin
        errors++; $display("FAIL nonmem_idle[%0d]: got %h exp %h", t, {obs, stall_o}, {2'b00, last, 1'b0});
      end
    end
  endtask

  task automatic test_mem();
    instr_t i;
    int nw;
    logic [7:0] rd;
    logic [39:0] e;
    for (int t = 0; t < 10; t++) begin
      if (t == 0) begin
        i = rand_instr(OP_LW); i.alu = 8'h20; nw = 3; rd = 8'hA5;
      end else if (t == 1) begin
        i = rand_instr(OP_SW); i.alu = 8'h10; i.d1 = 8'h7E; nw = 1; rd = 8'h5A;
      end else begin
        i = rand_instr(($urandom_range(0, 1) == 1) ? OP_LW : OP_SW);
        nw = $urandom_range(1, TMO);
        rd = 8'($urandom);
      end
      present(i, 1'b1);
      step();
      checks++;
      if (obs !== {2'b00, last}) begin errors++; $display("FAIL mem_accept[%0d]: got %h exp %h", t, obs, {2'b00, last}); end
      present(rand_instr(rand_alu_op()), 1'b0);
      for (int k = 1; k <= nw; k++) begin
        mem_ack = (k == nw);
        mem_rdata = (k == nw) ? rd : 8'($urandom);
        checks++;
        if (bus !== {2'b11, i.op == OP_SW, i.alu, i.d1} || valid_o !== 1'b0) begin
          errors++; $display("FAIL mem_wait[%0d.%0d]: got %h/%b exp %h/0", t, k, bus, valid_o, {2'b11, i.op == OP_SW, i.alu, i.d1});
        end
        step();
      end
      mem_ack = 1'b0;
      e = exp_out(i, rd, 1'b0);
      checks++;
      if (obs !== e || bus[18:16] !== 3'b000) begin
        errors++; $display("FAIL mem_done[%0d]: got %h/%b exp %h/000", t, obs, bus[18:16], e);
      end
      last = e[37:0];
      step();
      checks++;
      if (obs !== {2'b00, last}) begin errors++; $display("FAIL mem_idle[%0d]: got %h exp %h", t, obs, {2'b00, last}); end
    end
  endtask

  task automatic test_back_to_back();
    instr_t l, s, a;
    logic [7:0] rd;
    logic [39:0] e;
    l = rand_instr(OP_LW);
    s = rand_instr(OP_SW);
    a = rand_instr(rand_alu_op());
    rd = 8'($urandom);
    present(l, 1'b1);
    step();
    present(s, 1'b1);
    step();
    mem_ack = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    e = exp_out(l, rd, 1'b0);
    checks++;
    if (obs !== e || stall_o !== 1'b0) begin errors++; $display("FAIL b2b_load: got %h/%b exp %h/0", obs, stall_o, e); end
    last = e[37:0];
    step();
    checks++;
    if (obs !== {2'b00, last} || bus !== {3'b111, s.alu, s.d1}) begin
      errors++; $display("FAIL b2b_store_accept: got %h/%h exp %h/%h", obs, bus, {2'b00, last}, {3'b111, s.alu, s.d1});
    end
    present(a, 1'b1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    e = exp_out(s, 8'h00, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_store: got %h exp %h", obs, e); end
    step();
    present(rand_instr(4'h0), 1'b0);
    e = exp_out(a, 8'h00, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_alu: got %h exp %h", obs, e); end
    last = e[37:0];
    step();
  endtask

  task automatic test_reset_in_wait();
    present(rand_instr(OP_LW), 1'b1);
    step();
    present(rand_instr(4'h0), 1'b0);
    step();
    step();
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL rstw_pre: got %b exp 1", stall_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 8'hC3;
    checks++;
    if (obs !== 40'h0 || bus !== 19'h0) begin errors++; $display("FAIL rstw_clear: got %h/%h exp 0/0", obs, bus); end
    step();
    step();
    mem_ack = 1'b0;
    checks++;
    if (obs !== 40'h0 || bus !== 19'h0) begin errors++; $display("FAIL rstw_ack_ignored: got %h/%h exp 0/0", obs, bus); end
    last = '0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    instr_t i;
    logic [7:0] rd;
    logic [39:0] e;
    for (int run = 0; run < 2; run++) begin
      i = rand_instr(OP_LW);
      i.wr = 1'b1;
      rd = 8'($urandom);
      present(i, 1'b1);
      step();
      present(rand_instr(4'h0), 1'b0);
      for (int k = 1; k <= TMO; k++) begin
        mem_ack = (run == 1 && k == TMO);
        mem_rdata = rd;
        checks++;
        if (stall_o !== 1'b1 || valid_o !== 1'b0) begin
          errors++; $display("FAIL tmo_wait[%0d.%0d]: got %b%b exp 10", run, k, stall_o, valid_o);
        end
        step();
      end
      mem_ack = 1'b0;
      e = exp_out(i, rd, (run == 0));
      checks++;
      if (obs !== e || stall_o !== 1'b0) begin errors++; $display("FAIL tmo_done[%0d]: got %h/%b exp %h/0", run, obs, stall_o, e); end
      last = e[37:0];
      step();
      checks++;
      if (obs !== {2'b00, last}) begin errors++; $display("FAIL tmo_idle[%0d]: got %h exp %h", run, obs, {2'b00, last}); end
    end
  endtask
`else
  task automatic test_no_timeout();
    instr_t i;
    logic [7:0] rd;
    logic [39:0] e;
    int bad;
    i = rand_instr(OP_LW);
    rd = 8'($urandom);
    bad = 0;
    present(i, 1'b1);
    step();
    present(rand_instr(4'h0), 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (stall_o !== 1'b1 || valid_o !== 1'b0 || fault_o !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL notmo_wait: got %0d bad cycles exp 0", bad); end
    mem_ack = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    e = exp_out(i, rd, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL notmo_done: got %h exp %h", obs, e); end
    last = e[37:0];
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    present(rand_instr(4'h0), 1'b0);
    test_reset();
    test_nonmem();
    test_mem();
    test_back_to_back();
    test_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, max cycles waited in WAIT for mem_ack (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports valid_i/opcode_i/data1_i/alu_reg_i/writeReg_i/reg1_i/reg2_i/imm_i  input  1/4/8/8/1/3/3/3  instruction from EX/MEM register; alu_reg_i is the memory address for loads and stores, data1_i is the store data.
REQ-005 SHALL have port stall_o  output  1  upstream hold request.
REQ-006 SHALL have ports mem_req/mem_we/mem_addr/mem_wdata  output  1/1/8/8  data-memory request.
REQ-007 SHALL have ports mem_ack/mem_rdata  input  1/8  data-memory completion and read data.
REQ-008 SHALL have ports valid_o/opcode_o/data1_o/alu_reg_o/writeReg_o/reg1_o/reg2_o/imm_o/q_o  output  1/4/8/8/1/3/3/3/8  fields to MEM/WB; q_o is load data.
REQ-009 SHALL have port fault_o  output  1  memory timeout flag, qualified by valid_o.

Function
REQ-010 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-011 In IDLE, valid_i with a non-memory opcode SHALL register all fields to outputs and set valid_o=1 on the next edge, so latency is 1 cycle and q_o is 0.
REQ-012 In IDLE, valid_i with OP_LW or OP_SW SHALL latch all fields, go to WAIT, and set valid_o=0 on that edge.
REQ-013 In WAIT, mem_req SHALL be 1, with mem_we=1 for OP_SW only, mem_addr=latched alu_reg, and mem_wdata=latched data1; all four SHALL stay stable until ack.
REQ-014 stall_o SHALL equal (state==WAIT), combinationally; upstream holds its inputs while stall_o=1.
REQ-015 mem_ack in WAIT SHALL capture mem_rdata into q_o (OP_LW; for OP_SW q_o=0), set valid_o=1 on that edge, and return to IDLE; mem_req drops the following cycle.
REQ-016 mem_ack outside WAIT SHALL be ignored.
REQ-017 valid_o SHALL be a single-cycle pulse per instruction; with no accepted instruction valid_o=0 and other outputs hold their last value.
REQ-018 Back-to-back: the instruction presented in the cycle stall_o falls SHALL be accepted in that same cycle, with no bubble beyond the wait.
REQ-019 fault_o SHALL be 0 whenever valid_o=0.

Reset
REQ-020 rst SHALL, at the next edge, force state IDLE and set mem_req, mem_we, valid_o, writeReg_o, fault_o and stall_o to 0 and all data/field outputs to 0.
REQ-021 rst during WAIT SHALL abandon the access; a mem_ack arriving after reset SHALL be ignored.

Configuration
REQ-022 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES without ack it SHALL return to IDLE and pulse valid_o=1 with fault_o=1, writeReg_o=0 and q_o=0.
REQ-023 With MEM_TIMEOUT_EN defined, an ack in the same cycle the count reaches TIMEOUT_CYCLES SHALL win, completing normally with fault_o=0.
REQ-024 Without MEM_TIMEOUT_EN, WAIT SHALL persist until ack, no counter SHALL exist, and fault_o SHALL be tied to 0.

Structure
REQ-025 Package pipe_pkg SHALL hold the opcode constants OP_LW=4'h8 and OP_SW=4'h9, the state enum mem_state_t, and the field widths.
REQ-026 The block SHALL contain no sub-module; the FSM, counter and output registers are inline.

Verification
REQ-027 Non-memory op: opcode 4'h1, alu_reg_i 8'h3C, writeReg 1 -> next cycle valid_o=1, alu_reg_o=8'h3C, q_o=0, stall_o never set.
REQ-028 Load: OP_LW to address 8'h20, ack after 3 cycles with rdata 8'hA5 -> stall_o=1 for 3 cycles, mem_addr=8'h20, mem_we=0, q_o=8'hA5 with valid_o pulse.
REQ-029 Store: OP_SW with data1 8'h7E to address 8'h10, ack immediately -> mem_we=1, mem_wdata=8'h7E, one stall cycle, valid_o=1 with q_o=0.
REQ-030 Reset in WAIT: rst asserted 2 cycles into a load, then ack -> mem_req=0 and valid_o=0 after reset, ack ignored, state IDLE.
REQ-031 Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): load with no ack -> after 4 WAIT cycles valid_o=1 and fault_o=1 with writeReg_o=0; a second run with ack in cycle 4 gives fault_o=0.
